// File: rtl/pad_seq_pkg.sv
// Shared mode encodings, FSM states and width helpers for the pad sequencer.
package pad_seq_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE  = 2'b00,
    MODE_REC   = 2'b01,
    MODE_PLAY  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REC,
    S_FULL,
    S_PLAY
  } state_e;

  function automatic int key_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int step_w(input int d);
    return $clog2(d + 1);
  endfunction

  // Memory address width; step_idx carries one extra bit to reach DEPTH.
  function automatic int addr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/pad_sequencer_if.sv
// Keypad, control and note/tone outputs of the pad sequencer bundled as one port.
interface pad_sequencer_if #(
  parameter int N_KEYS = 12,
  parameter int DEPTH  = 16,
  parameter int OCT_W  = 2
);
  import pad_seq_pkg::*;

  localparam int KEY_W  = key_w(N_KEYS);
  localparam int STEP_W = step_w(DEPTH);

  logic [N_KEYS-1:0] BTN;
  logic [1:0]        mode;
  logic              step_tick;
  logic [OCT_W-1:0]  octave;
  logic [KEY_W-1:0]  Dout;
  logic              Dvalid;
  logic              Pout;
  logic [STEP_W-1:0] step_idx;
  logic [STEP_W-1:0] len;
  logic              full;

  modport master (
    output BTN, mode, step_tick, octave,
    input  Dout, Dvalid, Pout, step_idx, len, full
  );

  modport slave (
    input  BTN, mode, step_tick, octave,
    output Dout, Dvalid, Pout, step_idx, len, full
  );

endinterface

// File: rtl/pad_tone_gen.sv
// Square-wave tone: Pout toggles every (BASE_DIV - code*DIV_STEP) >> octave clocks while valid.
// A change of code or octave restarts the half-period counter; invalid forces Pout low.
module pad_tone_gen #(
  parameter int KEY_W    = 4,
  parameter int OCT_W    = 2,
  parameter int BASE_DIV = 1000,
  parameter int DIV_STEP = 40
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [KEY_W-1:0] code,
  input  logic             valid,
  input  logic [OCT_W-1:0] octave,
  output logic             Pout
);

  localparam int CNT_W = $clog2(BASE_DIV + 1);

  logic [31:0]      half;
  logic [CNT_W-1:0] half_m1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pout_q, pout_d;
  logic [KEY_W-1:0] code_q;
  logic [OCT_W-1:0] oct_q;

  always_comb begin
    half = (32'(BASE_DIV) - 32'(code) * 32'(DIV_STEP)) >> octave;
    if (half == 32'd0) begin
      half = 32'd1;
    end
    half_m1 = CNT_W'(half - 32'd1);

    cnt_d  = cnt_q;
    pout_d = pout_q;
    if (!valid) begin
      cnt_d  = '0;
      pout_d = 1'b0;
    end else if (code != code_q || octave != oct_q) begin
      cnt_d = '0;
    end else if (cnt_q == half_m1) begin
      cnt_d  = '0;
      pout_d = ~pout_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      pout_q <= 1'b0;
      code_q <= '0;
      oct_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pout_q <= pout_d;
      code_q <= code;
      oct_q  <= octave;
    end
  end

  assign Pout = pout_q;

endmodule

// File: rtl/pad_sequencer.sv
// Keypad step sequencer: live echo, record into DEPTH steps, looped playback, tone output.
// Define PAD_SEQ_OVERDUB_EN to let held keys overwrite the playing step on each tick.
module pad_sequencer
  import pad_seq_pkg::*;
#(
  parameter int N_KEYS   = 12,
  parameter int DEPTH    = 16,
  parameter int OCT_W    = 2,
  parameter int BASE_DIV = 1000,
  parameter int DIV_STEP = 40
) (
  input  logic            CLK,
  input  logic            RST,
  pad_sequencer_if.slave  bus
);

  localparam int KEY_W  = key_w(N_KEYS);
  localparam int STEP_W = step_w(DEPTH);
  localparam int ADDR_W = addr_w(DEPTH);

  state_e            state_q, state_d, tgt;
  mode_e             mode;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] len_q, len_d;
  logic              full_q, full_d;
  logic [KEY_W-1:0]  dout_q, dout_d;
  logic              dvld_q, dvld_d;
  logic              key_hit;
  logic [KEY_W-1:0]  key_code;
  logic              mem_we;
  logic [KEY_W:0]    mem_wdat, mem_rdat;
  logic [ADDR_W-1:0] addr;
  logic [KEY_W:0]    mem_q [DEPTH];

  // Lowest pressed key wins.
  always_comb begin
    key_hit  = |bus.BTN;
    key_code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (bus.BTN[i]) key_code = KEY_W'(i);
    end
  end

  assign mode     = mode_e'(bus.mode);
  assign addr     = step_q[ADDR_W-1:0];
  assign mem_rdat = mem_q[addr];

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    len_d    = len_q;
    full_d   = full_q;
    dout_d   = dout_q;
    dvld_d   = dvld_q;
    mem_we   = 1'b0;
    mem_wdat = {key_hit, key_code};

    unique case (mode)
      MODE_REC:  tgt = (state_q == S_FULL) ? S_FULL : S_REC;
      MODE_PLAY: tgt = S_PLAY;
      default:   tgt = S_IDLE;
    endcase

    if (mode == MODE_CLEAR) begin
      state_d = S_IDLE;
      step_d  = '0;
      len_d   = '0;
      full_d  = 1'b0;
      dout_d  = key_code;
      dvld_d  = key_hit;
    end else if (tgt != state_q) begin
      // Mode change wins over any tick in the same cycle.
      state_d = tgt;
      if (tgt == S_REC) begin
        step_d = '0;
        len_d  = '0;
        full_d = 1'b0;
      end else if (tgt == S_PLAY) begin
        step_d = '0;
      end
      dout_d = (tgt == S_PLAY) ? '0 : key_code;
      dvld_d = (tgt == S_PLAY) ? 1'b0 : key_hit;
    end else begin
      unique case (state_q)
        S_IDLE, S_FULL: begin
          dout_d = key_code;
          dvld_d = key_hit;
        end
        S_REC: begin
          dout_d = key_code;
          dvld_d = key_hit;
          if (bus.step_tick) begin
            mem_we = 1'b1;
            step_d = step_q + STEP_W'(1);
            len_d  = len_q + STEP_W'(1);
            if (step_q == STEP_W'(DEPTH - 1)) begin
              state_d = S_FULL;
              full_d  = 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (bus.step_tick && len_q != '0) begin
            {dvld_d, dout_d} = mem_rdat;
`ifdef PAD_SEQ_OVERDUB_EN
            if (key_hit) begin
              mem_we           = 1'b1;
              {dvld_d, dout_d} = {1'b1, key_code};
            end
`endif
            step_d = ((step_q + STEP_W'(1)) == len_q) ? '0 : step_q + STEP_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      len_q   <= '0;
      full_q  <= 1'b0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      full_q  <= full_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
    end
  end

  // Pattern memory is deliberately never cleared; len alone marks valid steps.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[addr] <= mem_wdat;
  end

  pad_tone_gen #(
    .KEY_W    (KEY_W),
    .OCT_W    (OCT_W),
    .BASE_DIV (BASE_DIV),
    .DIV_STEP (DIV_STEP)
  ) u_tone (
    .CLK    (CLK),
    .RST    (RST),
    .code   (dout_q),
    .valid  (dvld_q),
    .octave (bus.octave),
    .Pout   (bus.Pout)
  );

  assign bus.Dout     = dout_q;
  assign bus.Dvalid   = dvld_q;
  assign bus.step_idx = step_q;
  assign bus.len      = len_q;
  assign bus.full     = full_q;

endmodule

// File: tb/tb_pad_sequencer.sv
// Directed bench for pad_sequencer: live echo, record/play, full, clear, tone periods, reset, overdub.
module tb_pad_sequencer;

  localparam int N_KEYS = 12;
  localparam int DEPTH  = 16;
  localparam int OCT_W  = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  pad_sequencer_if #(.N_KEYS(N_KEYS), .DEPTH(DEPTH), .OCT_W(OCT_W)) bus ();

  pad_sequencer #(
    .N_KEYS   (N_KEYS),
    .DEPTH    (DEPTH),
    .OCT_W    (OCT_W),
    .BASE_DIV (1000),
    .DIV_STEP (40)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.step_tick = 1'b1;
    step();
    bus.step_tick = 1'b0;
  endtask

  task automatic press(input int k);
    bus.BTN = (k < 0) ? '0 : N_KEYS'(1 << k);
  endtask

  // Full Pout period between two rising edges, 0 on timeout.
  task automatic measure(output int period);
    int guard;
    int c;
    period = 0;
    guard  = 0;
    c      = 0;
    while (bus.Pout !== 1'b0 && guard < 6000) begin step(); guard++; end
    while (bus.Pout !== 1'b1 && guard < 6000) begin step(); guard++; end
    while (bus.Pout !== 1'b0 && guard < 6000) begin step(); guard++; c++; end
    while (bus.Pout !== 1'b1 && guard < 6000) begin step(); guard++; c++; end
    if (guard < 6000) period = c;
  endtask

  int exp_v [7] = '{1, 0, 1, 1, 0, 1, 1};
  int exp_d [7] = '{1, 0, 5, 1, 0, 5, 1};
  int per;

  initial begin
    rst           = 1'b1;
    bus.BTN       = '0;
    bus.mode      = 2'b00;
    bus.step_tick = 1'b0;
    bus.octave    = '0;
    step(2);
    check("rst_dout",   bus.Dout,     0);
    check("rst_dvalid", bus.Dvalid,   0);
    check("rst_pout",   bus.Pout,     0);
    check("rst_step",   bus.step_idx, 0);
    check("rst_len",    bus.len,      0);
    check("rst_full",   bus.full,     0);
    rst = 1'b0;

    // Live echo
    bus.BTN = 12'h014;
    step();
    check("live_dout",   bus.Dout,   2);
    check("live_dvalid", bus.Dvalid, 1);
    bus.BTN = '0;
    step();
    check("live_off", bus.Dvalid, 0);

    // Record 1, none, 5
    bus.mode = 2'b01;
    step();
    press(1);  tick();
    press(-1); tick();
    press(5);  tick();
    press(-1);
    check("rec_len",  bus.len,      3);
    check("rec_step", bus.step_idx, 3);

    bus.mode = 2'b10;
    step();
    check("play_entry", bus.Dvalid, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("play_v%0d", i), bus.Dvalid, exp_v[i]);
      if (exp_v[i] == 1) check($sformatf("play_d%0d", i), bus.Dout, exp_d[i]);
    end
    check("play_len",  bus.len,      3);
    check("play_step", bus.step_idx, 1);

    // Tick coinciding with mode change is dropped
    bus.mode = 2'b01;
    tick();
    check("chg_len",  bus.len,      0);
    check("chg_step", bus.step_idx, 0);

    // Fill all 16 steps, then one extra tick
    for (int i = 0; i < 17; i++) begin
      press(i % N_KEYS);
      tick();
      if (i == 15) begin
        check("full_flag16", bus.full, 1);
        check("full_len16",  bus.len,  16);
      end
    end
    press(-1);
    check("full_flag17", bus.full,     1);
    check("full_len17",  bus.len,      16);
    check("full_step17", bus.step_idx, 16);

    bus.mode = 2'b10;
    step();
    check("full_play_entry", bus.Dvalid, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("full_play%0d", i), {bus.Dvalid, bus.Dout}, {1'b1, 4'(i % N_KEYS)});
    end
    check("full_wrap", bus.step_idx, 0);

    // Clear
    bus.mode = 2'b11;
    step();
    check("clr_len",  bus.len,      0);
    check("clr_full", bus.full,     0);
    check("clr_step", bus.step_idx, 0);

    // Tone periods in live mode
    bus.mode = 2'b00;
    press(0);
    step();
    measure(per);
    check("tone_k0_o0", per, 2000);
    bus.octave = 2'd2;
    measure(per);
    check("tone_k0_o2", per, 500);
    bus.octave = 2'd0;
    press(11);
    measure(per);
    check("tone_k11_o0", per, 1120);
    press(-1);
    step(2);
    check("tone_off", bus.Pout, 0);

    // Reset in the middle of playback
    bus.mode = 2'b01;
    step();
    press(1); tick();
    press(2); tick();
    press(3); tick();
    press(-1);
    bus.mode = 2'b10;
    step();
    tick();
    tick();
    check("mid_step", bus.step_idx, 2);
    check("mid_dout", bus.Dout,     2);
    rst = 1'b1;
    step();
    check("mrst_dout",   bus.Dout,     0);
    check("mrst_dvalid", bus.Dvalid,   0);
    check("mrst_pout",   bus.Pout,     0);
    check("mrst_step",   bus.step_idx, 0);
    check("mrst_len",    bus.len,      0);
    check("mrst_full",   bus.full,     0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("empty_play%0d", i), bus.Dvalid, 0);
    end

    // Keys held during playback
    bus.mode = 2'b01;
    step();
    press(1); tick();
    press(2); tick();
    press(3); tick();
    press(-1);
    bus.mode = 2'b10;
    step();
    tick();
    check("od_s0", bus.Dout, 1);
    press(7);
    tick();
`ifdef PAD_SEQ_OVERDUB_EN
    check("od_s1_now", bus.Dout, 7);
`else
    check("od_s1_now", bus.Dout, 2);
`endif
    press(-1);
    tick();
    check("od_s2", bus.Dout, 3);
    tick();
    check("od_s0b", bus.Dout, 1);
    tick();
`ifdef PAD_SEQ_OVERDUB_EN
    check("od_s1_loop", bus.Dout, 7);
`else
    check("od_s1_loop", bus.Dout, 2);
`endif
    check("od_s1_vld", bus.Dvalid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_sequencer.md
PAD_SEQUENCER -- requirements
Module: pad_sequencer

Interface
REQ-001 Parameters SHALL be: N_KEYS, default 12, number of keypad buttons; DEPTH, default 16, number of sequence steps; OCT_W, default 2, octave select width; BASE_DIV, default 1000, lowest-note tone half-period in clocks; DIV_STEP, default 40, half-period decrement per key index.
REQ-002 Derived widths SHALL be KEY_W = clog2(N_KEYS) and STEP_W = clog2(DEPTH+1); BASE_DIV SHALL exceed (N_KEYS-1)*DIV_STEP.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports: CLK  in  1  system clock, all state on rising edge.
REQ-005 Ports: RST  in  1  synchronous active-high reset.
REQ-006 Ports: BTN  in  N_KEYS  key levels; bit i is key i.
REQ-007 Ports: mode  in  2  00 LIVE, 01 RECORD, 10 PLAY, 11 CLEAR.
REQ-008 Ports: step_tick  in  1  single-cycle step strobe.
REQ-009 Ports: octave  in  OCT_W  right-shift applied to tone half-period.
REQ-010 Ports: Dout  out  KEY_W  current note code; Dvalid  out  1  note active.
REQ-011 Ports: Pout  out  1  square-wave tone; step_idx  out  STEP_W; len  out  STEP_W; full  out  1.

Function
REQ-012 Key encode SHALL be combinational: key_hit = OR of BTN; key_code = index of lowest set bit; simultaneous presses resolve to the lowest index.
REQ-013 The FSM SHALL have states IDLE, REC, FULL, PLAY; mode 01 -> REC (from IDLE/PLAY), 10 -> PLAY, 00 -> IDLE, 11 -> IDLE with len=0, step_idx=0, full=0 in one cycle.
REQ-014 Entry into REC or PLAY from another state SHALL zero step_idx; entry into REC SHALL also zero len.
REQ-015 IDLE (LIVE): Dout/Dvalid SHALL register {key_code, key_hit} with 1-cycle latency; step_idx held.
REQ-016 REC: on step_tick, mem[step_idx] <= {key_hit, key_code}, step_idx and len increment; live echo as in IDLE.
REQ-017 REC when step_idx reaches DEPTH after a write SHALL enter FULL: full=1, further ticks ignored, len=DEPTH.
REQ-018 FULL SHALL leave only on mode change; mode 01 while in FULL holds FULL.
REQ-019 PLAY with len=0 SHALL hold Dvalid=0 and ignore ticks.
REQ-020 PLAY with len>0: on step_tick, {Dvalid, Dout} <= mem[step_idx] one cycle later; step_idx <= 0 if step_idx+1 == len else step_idx+1.
REQ-021 Tone: while Dvalid=1, Pout SHALL toggle every H = (BASE_DIV - Dout*DIV_STEP) >> octave clocks (min 1); Dvalid=0 forces Pout=0 and counter 0; a Dout or octave change restarts the counter.
REQ-022 step_tick and mode change in the same cycle: mode change SHALL take priority; the tick is dropped.
REQ-023 Memory SHALL not be cleared by CLEAR or RST; validity is governed solely by len.

Reset
REQ-024 RST SHALL force state IDLE, step_idx=0, len=0, full=0, Dout=0, Dvalid=0, Pout=0, tone counter 0, regardless of the operation in progress.

Configuration
REQ-025 With PAD_SEQ_OVERDUB_EN defined, PLAY with key_hit=1 on step_tick SHALL write {1, key_code} to mem[step_idx] and output it that step; undefined, keys SHALL be ignored in PLAY.

Structure
REQ-026 Package pad_seq_pkg SHALL hold the mode encodings, FSM state enum, and the clog2-based width helpers.
REQ-027 The tone generator SHALL be sub-module pad_tone_gen (inputs code, valid, octave; output Pout).

Verification
REQ-028 Live: BTN=0x014, mode=00 -> Dout=2, Dvalid=1 next cycle; BTN=0 -> Dvalid=0.
REQ-029 Record 3 ticks with keys 1,none,5 then PLAY 7 ticks -> Dout/Dvalid sequence 1/1,x/0,5/1,1/1,x/0,5/1,1/1; len=3.
REQ-030 Record 17 ticks at DEPTH=16 -> full=1 after tick 16, len=16, tick 17 no write.
REQ-031 Dout=0, octave=0, defaults -> Pout period 2000 clocks; octave=2 -> 500; Dout=11 -> 1120.
REQ-032 RST asserted mid-PLAY at step 2 -> all outputs 0 next cycle; PLAY re-entry with len=0 -> Dvalid stays 0.
REQ-033 PAD_SEQ_OVERDUB_EN: PLAY with key 7 held on step 1 -> next loop step 1 yields Dout=7.
